// File: rtl/mem_access_ctrl_pkg.sv
// Shared size codes and controller state type for the MEM-stage access controller.
package mem_access_ctrl_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_align_unit.sv
// Combinational lane logic: request fault decode, load extract/extend, sub-word store merge.
module mem_access_ctrl_align_unit
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 2048
) (
  input  logic                  valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            lane_size,
  input  logic [1:0]            lane_off,
  input  logic                  lane_unsigned,
  input  logic [ADDR_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] ram_dout,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] load_data,
  output logic [ADDR_WIDTH-1:0] merge_data
);

  localparam logic [ADDR_WIDTH-3:0] DEPTH = (ADDR_WIDTH-2)'(RAM_DEPTH);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sign;

  always_comb begin
    fault = 1'b0;
    if (valid && (mem_read || mem_write)) begin
      if (mem_read && mem_write)               fault = 1'b1;
      if (size == 2'b10)                       fault = 1'b1;
      if (size == MEM_HALF && addr[0])         fault = 1'b1;
      if (size == MEM_WORD && addr[1:0] != '0) fault = 1'b1;
      if (addr[ADDR_WIDTH-1:2] >= DEPTH)       fault = 1'b1;
    end
  end

  always_comb begin
    lane_byte = ram_dout[{lane_off, 3'b000} +: 8];
    lane_half = ram_dout[{lane_off[1], 4'b0000} +: 16];
    sign      = 1'b0;
    load_data = ram_dout;
    case (lane_size)
      MEM_BYTE: begin
        sign      = ~lane_unsigned & lane_byte[7];
        load_data = {{(ADDR_WIDTH-8){sign}}, lane_byte};
      end
      MEM_HALF: begin
        sign      = ~lane_unsigned & lane_half[15];
        load_data = {{(ADDR_WIDTH-16){sign}}, lane_half};
      end
      default: load_data = ram_dout;
    endcase
  end

  always_comb begin
    merge_data = ram_dout;
    case (lane_size)
      MEM_BYTE: merge_data[{lane_off, 3'b000} +: 8]     = wdata[7:0];
      MEM_HALF: merge_data[{lane_off[1], 4'b0000} +: 16] = wdata[15:0];
      default:  merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller in front of ram_datos: word stores direct, sub-word stores as
// read-modify-write, loads aligned/extended with the pipeline stalled for RAM latency.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_DEPTH  = 2048,
  parameter int RD_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ADDR_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_ram_dout,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [ADDR_WIDTH-1:0] o_ram_din,
  output logic                  o_ram_we,
  output logic                  o_ram_en,
  output logic                  o_ram_regce,
  output logic                  o_ram_rst,
  output logic [ADDR_WIDTH-1:0] o_rdata,
  output logic                  o_rdata_valid,
  output logic                  o_stall,
  output logic                  o_fault
);

  localparam logic [1:0] LAST = 2'(RD_LATENCY);

  state_t                state, state_next;
  logic [1:0]            cnt, cnt_next;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic                  fault;
  logic [ADDR_WIDTH-1:0] load_data;
  logic [ADDR_WIDTH-1:0] merge_data;

  mem_access_ctrl_align_unit #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RAM_DEPTH  (RAM_DEPTH)
  ) u_align (
    .valid         (i_valid),
    .mem_read      (i_mem_read),
    .mem_write     (i_mem_write),
    .size          (i_size),
    .addr          (i_addr),
    .lane_size     (req_size),
    .lane_off      (req_addr[1:0]),
    .lane_unsigned (req_unsigned),
    .wdata         (req_wdata),
    .ram_dout      (i_ram_dout),
    .fault         (fault),
    .load_data     (load_data),
    .merge_data    (merge_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_size     <= '0;
      req_unsigned <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        req_addr     <= i_addr;
        req_wdata    <= i_wdata;
        req_size     <= i_size;
        req_unsigned <= i_unsigned;
      end
    end
  end

  assign o_ram_rst = i_reset;

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    capture       = 1'b0;
    o_ram_addr    = {2'b00, i_addr[ADDR_WIDTH-1:2]};
    o_ram_din     = '0;
    o_ram_we      = 1'b0;
    o_ram_en      = 1'b0;
    o_ram_regce   = 1'b0;
    o_rdata       = '0;
    o_rdata_valid = 1'b0;
    o_stall       = 1'b0;
    o_fault       = 1'b0;

    case (state)
      IDLE: begin
        if (fault) begin
          o_fault = 1'b1;
        end else if (i_valid && i_mem_write && i_size == MEM_WORD) begin
          o_ram_we  = 1'b1;
          o_ram_din = i_wdata;
        end else if (i_valid && (i_mem_read || i_mem_write)) begin
          o_ram_en   = 1'b1;
          o_stall    = 1'b1;
          capture    = 1'b1;
          cnt_next   = 2'd1;
          state_next = i_mem_read ? RD_WAIT : RMW_WAIT;
        end
      end
      RD_WAIT, RMW_WAIT: begin
        o_ram_addr  = {2'b00, req_addr[ADDR_WIDTH-1:2]};
        o_ram_en    = 1'b1;
        o_ram_regce = 1'b1;
        if (cnt < LAST) begin
          o_stall  = 1'b1;
          cnt_next = cnt + 2'd1;
        end else begin
          state_next = IDLE;
          if (state == RD_WAIT) begin
            o_rdata       = load_data;
            o_rdata_valid = 1'b1;
          end else begin
            o_ram_we  = 1'b1;
            o_ram_din = merge_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Reset is synchronous, so the outputs are gated here to stay quiet in the reset cycle itself
    // (this is what keeps an interrupted read-modify-write from ever writing).
    if (i_reset) begin
      o_ram_addr    = '0;
      o_ram_din     = '0;
      o_ram_we      = 1'b0;
      o_ram_en      = 1'b0;
      o_ram_regce   = 1'b0;
      o_rdata       = '0;
      o_rdata_valid = 1'b0;
      o_stall       = 1'b0;
      o_fault       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two builds (RD_LATENCY 2 and 1) share one ram_datos model;
// results are checked against a word-array reference using shift/mask arithmetic.
module tb_mem_access_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  logic        clk = 1'b0;
  logic        reset, valid, mem_read, mem_write, uns, sel, fill;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic [31:0] a_addr, a_din, a_rdata, b_addr, b_din, b_rdata;
  logic        a_we, a_en, a_regce, a_rst, a_rdv, a_stall, a_fault;
  logic        b_we, b_en, b_regce, b_rst, b_rdv, b_stall, b_fault;

  logic [31:0] ram [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] s1, dout;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(32), .RAM_DEPTH(2048), .RD_LATENCY(2)) dut_hp (
    .i_clk(clk), .i_reset(reset), .i_valid(valid & ~sel), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_size(size), .i_unsigned(uns), .i_addr(addr),
    .i_wdata(wdata), .i_ram_dout(dout), .o_ram_addr(a_addr), .o_ram_din(a_din),
    .o_ram_we(a_we), .o_ram_en(a_en), .o_ram_regce(a_regce), .o_ram_rst(a_rst),
    .o_rdata(a_rdata), .o_rdata_valid(a_rdv), .o_stall(a_stall), .o_fault(a_fault)
  );

  mem_access_ctrl #(.ADDR_WIDTH(32), .RAM_DEPTH(2048), .RD_LATENCY(1)) dut_ll (
    .i_clk(clk), .i_reset(reset), .i_valid(valid & sel), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_size(size), .i_unsigned(uns), .i_addr(addr),
    .i_wdata(wdata), .i_ram_dout(dout), .o_ram_addr(b_addr), .o_ram_din(b_din),
    .o_ram_we(b_we), .o_ram_en(b_en), .o_ram_regce(b_regce), .o_ram_rst(b_rst),
    .o_rdata(b_rdata), .o_rdata_valid(b_rdv), .o_stall(b_stall), .o_fault(b_fault)
  );

  // Observed view follows the selected build; the idle build drives no strobes.
  logic [31:0] ram_addr, ram_din, rdata;
  logic        we, en, regce, ram_rst, rdata_valid, stall, fault;
  assign ram_addr    = sel ? b_addr  : a_addr;
  assign ram_din     = sel ? b_din   : a_din;
  assign rdata       = sel ? b_rdata : a_rdata;
  assign we          = sel ? b_we    : a_we;
  assign en          = sel ? b_en    : a_en;
  assign regce       = sel ? b_regce : a_regce;
  assign ram_rst     = sel ? b_rst   : a_rst;
  assign rdata_valid = sel ? b_rdv   : a_rdv;
  assign stall       = sel ? b_stall : a_stall;
  assign fault       = sel ? b_fault : a_fault;

  function automatic logic [31:0] fill_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 2048; i++) ram[i] <= fill_word(i);
    end else begin
      if (a_we | b_we) ram[ram_addr[10:0]] <= ram_din;
      if (a_en | b_en) s1 <= ram[ram_addr[10:0]];
      if (sel) begin
        if (b_en) dout <= ram[ram_addr[10:0]];
      end else if (a_regce) begin
        dout <= s1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet_chk(input string tag);
    chk({tag, "_strobes"}, 32'({stall, fault, en, we, regce, rdata_valid}), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic reset_out_chk();
    quiet_chk("rst");
    chk("rst_bus", ram_addr | ram_din, 32'd0);
    chk("rst_ram_rst", 32'(ram_rst), 32'd1);
  endtask

  task automatic idle_chk();
    valid = 1'b0;
    @(negedge clk);
    quiet_chk("idle");
    chk("idle_ram_rst", 32'(ram_rst), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    valid = 1'b1; mem_read = rd; mem_write = wr; size = sz; uns = u; addr = a; wdata = wd;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    logic        flt;
    logic [31:0] w, m, exp_rd, exp_din;
    int unsigned sh, exp_st, stalls;
    bit          done;
    w   = ref_mem[a[12:2]];
    sh  = 8 * int'(a[1:0]);
    flt = (rd && wr) || sz == 2'b10 || (sz == SZ_H && a[0]) ||
          (sz == SZ_W && a[1:0] != 2'b00) || (a / 4 >= 2048);
    exp_st = (flt || (wr && sz == SZ_W)) ? 0 : (sel ? 1 : 2);
    case (sz)
      SZ_B: begin
        exp_rd = (w >> sh) & 32'hFF;
        if (!u && exp_rd[7]) exp_rd = exp_rd | 32'hFFFFFF00;
      end
      SZ_H: begin
        exp_rd = (w >> sh) & 32'hFFFF;
        if (!u && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF0000;
      end
      default: exp_rd = w;
    endcase
    m = (sz == SZ_B) ? (32'hFF << sh) : (sz == SZ_H) ? (32'hFFFF << sh) : 32'hFFFFFFFF;
    exp_din = (w & ~m) | ((wd << sh) & m);

    drive(rd, wr, sz, u, a, wd);
    stalls = 0;
    done   = 0;
    for (int c = 0; c < 5 && !done; c++) begin
      @(negedge clk);
      if (stall) begin
        chk("stall_strobes", 32'({en, we, rdata_valid, fault, regce}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, c > 0}));
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1;
        chk("stall_cycles", stalls, exp_st);
        chk("fault", 32'(fault), 32'(flt));
        if (flt) begin
          chk("fault_strobes", 32'({en, we, rdata_valid}), 32'd0);
        end else if (rd) begin
          chk("rdata_valid", 32'({rdata_valid, we}), 32'b10);
          chk("rdata", rdata, exp_rd);
          chk("ld_ram_addr", ram_addr, a >> 2);
        end else begin
          chk("st_we", 32'({we, rdata_valid}), 32'b10);
          chk("st_din", ram_din, exp_din);
          chk("st_ram_addr", ram_addr, a >> 2);
          chk("st_rdata", rdata, 32'd0);
          ref_mem[a[12:2]] = exp_din;
        end
      end
    end
    if (!done) chk("timeout_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_mid(input logic rd, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int unsigned at);
    drive(rd, !rd, sz, 1'b0, a, wd);
    repeat (at) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(negedge clk);
    reset_out_chk();
    @(posedge clk); #1;
    reset = 1'b0;
    idle_chk();
  endtask

  task automatic rand_txn();
    logic        rd, wr;
    logic [1:0]  sz;
    logic [31:0] a;
    int unsigned op, pick, off;
    op   = $urandom_range(0, 15);
    rd   = (op < 7) || (op == 15);
    wr   = (op >= 7);
    pick = $urandom_range(0, 9);
    sz   = (pick == 0) ? 2'b10 : (pick < 4) ? SZ_B : (pick < 7) ? SZ_H : SZ_W;
    off  = $urandom_range(0, 3);
    if ($urandom_range(0, 3) != 0) off = (sz == SZ_W) ? 0 : (sz == SZ_H) ? (off & 2) : off;
    a = (32'($urandom_range(0, 15)) << 2) | 32'(off);
    if ($urandom_range(0, 19) == 0) a = 32'h1FFC + 32'($urandom_range(0, 1) * 4);
    txn(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
    if ($urandom_range(0, 3) == 0) idle_chk();
  endtask

  initial begin
    reset = 1'b1; fill = 1'b1; sel = 1'b0;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = SZ_W; uns = 1'b0;
    addr = '0; wdata = '0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = fill_word(i);
    @(posedge clk); #1;
    fill = 1'b0;
    @(negedge clk);
    reset_out_chk();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    reset_out_chk();
    @(posedge clk); #1;
    reset = 1'b0;
    idle_chk();

    txn(1'b0, 1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    txn(1'b1, 1'b0, SZ_B, 1'b0, 32'h13, 32'h0);
    txn(1'b1, 1'b0, SZ_B, 1'b1, 32'h13, 32'h0);
    txn(1'b1, 1'b0, SZ_H, 1'b0, 32'h12, 32'h0);
    txn(1'b1, 1'b0, SZ_H, 1'b1, 32'h10, 32'h0);
    txn(1'b0, 1'b1, SZ_B, 1'b0, 32'h11, 32'hAA);
    txn(1'b0, 1'b1, SZ_H, 1'b0, 32'h12, 32'h1234);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);

    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h11, 32'h0);
    txn(1'b1, 1'b0, SZ_H, 1'b0, 32'h13, 32'h0);
    txn(1'b0, 1'b1, SZ_W, 1'b0, 32'h2000, 32'h0BAD0BAD);
    txn(1'b1, 1'b1, SZ_W, 1'b0, 32'h14, 32'h0BAD0BAD);
    txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0BAD0BAD);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h14, 32'h0);
    txn(1'b0, 1'b1, SZ_B, 1'b0, 32'h1FFF, 32'h77);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h1FFC, 32'h0);
    idle_chk();

    reset_mid(1'b0, SZ_B, 32'h10, 32'h55, 1);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    reset_mid(1'b0, SZ_B, 32'h10, 32'h66, 2);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h10, 32'h0);
    reset_mid(1'b1, SZ_W, 32'h10, 32'h0, 2);
    txn(1'b1, 1'b0, SZ_B, 1'b0, 32'h10, 32'h0);

    repeat (80) rand_txn();
    idle_chk();

    sel = 1'b1;
    idle_chk();
    txn(1'b0, 1'b1, SZ_B, 1'b0, 32'h21, 32'h5A);
    txn(1'b1, 1'b0, SZ_B, 1'b0, 32'h21, 32'h0);
    txn(1'b0, 1'b1, SZ_W, 1'b0, 32'h24, 32'h80C0FFEE);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h24, 32'h0);
    txn(1'b1, 1'b0, SZ_H, 1'b0, 32'h26, 32'h0);
    txn(1'b0, 1'b1, SZ_H, 1'b0, 32'h20, 32'hFFFF9ABC);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    reset_mid(1'b0, SZ_H, 32'h20, 32'h1111, 1);
    txn(1'b1, 1'b0, SZ_W, 1'b0, 32'h20, 32'h0);
    repeat (80) rand_txn();
    idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
